// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - sequential instruction prefetch FIFO with redirect flush
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   add_bus, bus_req    instruction-bus address (fetch PC) and fetch request
//   data_bus, isCplt    instruction-bus read data and its completion strobe
//   isStop              global freeze of fetch, push and pop
//   redirect,
//   redirect_pc         flush the queue and restart fetch at redirect_pc
//   take                decode consumes the head entry
//   order,
//   nextOrderAddress    head instruction and its address (0 when empty)
//   next_isRunning      head entry valid
//   count               occupied entries

module fetch_prefetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [ADDR_W-1:0]           add_bus,
  output logic                        bus_req,
  input  logic [DATA_W-1:0]           data_bus,
  input  logic                        isCplt,
  input  logic                        isStop,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  input  logic                        take,
  output logic [DATA_W-1:0]           order,
  output logic [ADDR_W-1:0]           nextOrderAddress,
  output logic                        next_isRunning,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];

  logic req;
  logic push;
  logic pop;
  logic head_valid;

  always_comb begin
    head_valid = (count_q != '0);
    // A full queue drops the request; the slot freed by a pop is only
    // seen on the following cycle, which costs one bubble.
    req  = rst && !isStop && !redirect && (count_q < DEPTH_C);
    push = req && isCplt;
    pop  = take && head_valid && !isStop && !redirect;

    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;

    if (redirect) begin
      // Flush wins over freeze and discards any same-cycle completion.
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        addr_mem_d[wr_ptr_q] = pc_q;
        data_mem_d[wr_ptr_q] = data_bus;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        pc_d                 = pc_q + STEP_C;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  assign add_bus          = pc_q;
  assign bus_req          = req;
  assign count            = count_q;
  assign next_isRunning   = head_valid;
  assign order            = head_valid ? data_mem_q[rd_ptr_q] : '0;
  assign nextOrderAddress = head_valid ? addr_mem_q[rd_ptr_q] : '0;

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised instruction-fetch front end for the 023A core. Fetches sequential instruction words over the instruction bus into a DEPTH-entry prefetch FIFO, so the decode stage sees one {address, instruction} pair per cycle even when bus latency varies. Branch, call, return and interrupt logic redirects it with redirect/redirect_pc, which flushes all prefetched entries. Unlike a single-register fetch stage, it buffers several instructions, tolerates multi-cycle bus completion, and supports parametrised width and step.

Parameters:
ADDR_W, 32, width of fetch PC and instruction-bus address
DATA_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
PC_STEP, 4, byte increment between sequential fetches
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
add_bus  out  ADDR_W  instruction-bus address (= fetch PC)
bus_req  out  1  fetch request; add_bus is valid while high
data_bus  in  DATA_W  instruction-bus read data
isCplt  in  1  bus completion; data_bus is valid this cycle
isStop  in  1  global freeze; blocks fetch, push and pop
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
take  in  1  decode consumes the head entry this cycle
order  out  DATA_W  head instruction; 0 when empty
nextOrderAddress  out  ADDR_W  address of head instruction; 0 when empty
next_isRunning  out  1  head entry valid (FIFO not empty)
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): fetch PC=RESET_PC, FIFO pointers=0, count=0, next_isRunning=0, order=0, nextOrderAddress=0, bus_req=0.
- bus_req = rst && !isStop && !redirect && (count < DEPTH). add_bus = fetch PC at all times.
- Push: on a cycle with bus_req=1 and isCplt=1, write {fetch PC, data_bus} at the write pointer and set fetch PC += PC_STEP, wrapping modulo 2^ADDR_W. If isCplt=1 while bus_req=0, ignore it.
- Pop: on a cycle with take=1, next_isRunning=1, isStop=0 and redirect=0, advance the read pointer. take while empty is ignored.
- Simultaneous push and pop: count is unchanged. Both are legal when count=DEPTH-1. When count=DEPTH, bus_req=0, so there is no push; a pop that cycle lets bus_req rise the following cycle (one-cycle bubble is accepted).
- count(next) = count + push - pop. Pointers are log2(DEPTH) bits and wrap naturally.
- Outputs order/nextOrderAddress/next_isRunning are combinational from the head entry and count. order and nextOrderAddress are forced to 0 when count=0.
- Redirect (priority over everything, including isStop): at the next edge, FIFO is flushed (pointers=0, count=0) and fetch PC=redirect_pc. Any isCplt in the same cycle is discarded. In the cycle after the redirect, next_isRunning=0, and a fetch at redirect_pc is requested if isStop=0.
- isStop=1 (and no redirect): no push, no pop, fetch PC held, FIFO contents preserved, and bus_req=0. Fetch resumes from the held PC when isStop falls.
- Latency: isCplt at edge N makes the entry visible at head after edge N, if the FIFO was empty.
- Reset asserted mid-fetch: all state is cleared immediately; no partial entry survives.

Test Plan:
- Reset release, isCplt held 1, take=0, data_bus = 0x100+addr -> add_bus steps 0, 4, 8, 12; count reaches 4; bus_req=0; head = {0x0, 0x100}.
- FIFO full, take=1 for one cycle -> count 4→3; head address 0x4; bus_req=1 next cycle fetching 0x10.
- Steady stream with isCplt=1 and take=1 every cycle -> count constant at 1; nextOrderAddress increments by 4 each cycle; no entry lost or duplicated.
- Redirect to 0x2000 while count=3 and isCplt=1 same cycle -> next cycle count=0, next_isRunning=0, add_bus=0x2000; first subsequent head = {0x2000, data}.
- isStop=1 for 3 cycles with count=2 and isCplt=1 -> count stays 2, PC unchanged, bus_req=0; after release, fetch continues from the held PC.
- isCplt delayed 3 cycles per fetch; also fetch PC=0xFFFFFFFC with isCplt -> add_bus holds its value until isCplt; the PC=0xFFFFFFFC fetch wraps the next PC to 0x00000000.
